// File: rtl/if_fetch.sv
// WISC instruction fetch: PC throttling, single-outstanding imem handshake,
// 2-entry {pc, instr} queue toward decode, flush and HLT handling.
module if_fetch #(
  parameter int          DEPTH  = 2,
  parameter logic [3:0]  HLT_OP = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_in,
  output logic        pc_hlt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        dec_stall,
  input  logic        flush,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP,
    HALT
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] pc_q  [2];
  logic [15:0] pc_d  [2];
  logic [15:0] ins_q [2];
  logic [15:0] ins_d [2];
  logic        req_q, req_d;
  logic [15:0] addr_q, addr_d;
  logic        halted_q, halted_d;

  logic issue;
  logic ack;
  logic deq;
  logic enq;
  logic wr;
  logic is_hlt;

  assign issue  = rst_n & (state_q == IDLE) & ~flush
                & (count_q < 2'(DEPTH));
  assign ack    = req_q & imem_ack;
  assign deq    = (count_q != 2'd0) & ~dec_stall & ~flush;
  assign enq    = (state_q == WAIT) & ack & ~flush;
  assign is_hlt = imem_rdata[15:12] == HLT_OP;
  // write slot after any same-cycle dequeue has shifted the head out
  assign wr     = count_q[1] | (count_q[0] & ~deq);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pc_d     = pc_q;
    ins_d    = ins_q;
    req_d    = req_q;
    addr_d   = addr_q;
    halted_d = halted_q;

    if (flush) begin
      count_d  = 2'd0;
      halted_d = 1'b0;
    end else begin
      count_d = count_q + {1'b0, enq} - {1'b0, deq};
    end

    if (deq) begin
      pc_d[0]  = pc_q[1];
      ins_d[0] = ins_q[1];
    end
    if (enq) begin
      pc_d[wr]  = addr_q;
      ins_d[wr] = imem_rdata;
    end

    unique case (state_q)
      IDLE: begin
        if (issue) begin
          req_d   = 1'b1;
          addr_d  = pc_in;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ack) begin
          req_d = 1'b0;
          if (flush) begin
            state_d = IDLE;
          end else if (is_hlt) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      HALT: begin
        if (flush) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= 2'd0;
      req_q    <= 1'b0;
      addr_q   <= 16'h0000;
      halted_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        pc_q[i]  <= 16'h0000;
        ins_q[i] <= 16'h0000;
      end
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      halted_q <= halted_d;
      pc_q     <= pc_d;
      ins_q    <= ins_d;
    end
  end

  assign pc_hlt      = ~issue;
  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign halted      = halted_q;
  assign instr_valid = count_q != 2'd0;
  assign instr       = instr_valid ? ins_q[0] : 16'h0000;
  assign instr_pc    = instr_valid ? pc_q[0] : 16'h0000;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: vector table, directed corner sequences and
// random traffic against a queue-based reference model.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc_in = 16'h0000;
  logic        pc_hlt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        dec_stall = 1'b0;
  logic        flush = 1'b0;
  logic        halted;

  if_fetch dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_hlt(pc_hlt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .dec_stall(dec_stall), .flush(flush),
    .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int          lat = 0;
  int          wcnt;
  logic        rand_mode = 1'b0;
  logic        ack_rand = 1'b0;
  logic        hlt_rand = 1'b0;
  logic        hlt_en = 1'b0;
  logic [15:0] hlt_addr = 16'h0000;

  function automatic logic [15:0] mem_word(input logic [15:0] a,
                                           input logic he,
                                           input logic [15:0] ha,
                                           input logic hr);
    if (he && a == ha) return 16'hF000;
    if (hr) return {4'hF, a[11:0]};
    return {4'h1, a[11:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr, hlt_en, hlt_addr,
                               rand_mode & hlt_rand);
  assign imem_ack = imem_req & (rand_mode ? ack_rand : (wcnt >= lat));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic        m_out;
  logic        m_drop;
  logic        m_halt;
  logic [15:0] m_addr;
  logic        m_issue;

  task automatic chk16(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out  = 1'b0;
    m_drop = 1'b0;
    m_halt = 1'b0;
    m_addr = 16'h0000;
  endtask

  task automatic drive(input logic st, input logic fl);
    dec_stall = st;
    flush     = fl;
    if (rand_mode) begin
      ack_rand = 1'($urandom);
      hlt_rand = ($urandom_range(0, 19) == 0);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    m_issue = !m_out && !m_halt && !flush && mq.size() < 2;
    chk1("m_pc_hlt", pc_hlt, !m_issue);
    chk1("m_req", imem_req, m_out);
    chk16("m_addr", imem_addr, m_addr);
    chk1("m_valid", instr_valid, mq.size() != 0);
    chk16("m_instr", instr, mq.size() != 0 ? mq[0].ins : 16'h0000);
    chk16("m_ipc", instr_pc, mq.size() != 0 ? mq[0].pc : 16'h0000);
    chk1("m_halted", halted, m_halt);
  endtask

  task automatic advance();
    logic        a;
    logic [15:0] w;
    a = m_out && imem_ack;
    w = mem_word(m_addr, hlt_en, hlt_addr, rand_mode & hlt_rand);
    if (flush) begin
      mq.delete();
      m_halt = 1'b0;
      if (a) m_out = 1'b0;
      m_drop = m_out;
    end else begin
      if (mq.size() != 0 && !dec_stall) void'(mq.pop_front());
      if (a) begin
        m_out = 1'b0;
        if (!m_drop) begin
          mq.push_back('{pc: m_addr, ins: w});
          if (w[15:12] == 4'hF) m_halt = 1'b1;
        end
        m_drop = 1'b0;
      end
    end
    if (m_issue) begin
      m_out  = 1'b1;
      m_addr = pc_in;
      m_drop = 1'b0;
    end
    @(posedge clk);
    #1;
    if (m_issue) pc_in = pc_in + 16'd1;
  endtask

  task automatic cyc(input logic st, input logic fl);
    drive(st, fl);
    sample();
    advance();
  endtask

  typedef struct {
    logic        st;
    logic        fl;
    logic        e_hlt;
    logic        e_req;
    logic        e_val;
    logic [15:0] e_pc;
    logic [15:0] e_ins;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic found;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h1000};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h1001};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 16'h1002};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0003, 16'h1003};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_pc_hlt", pc_hlt, 1'b1);
    chk1("rst_req", imem_req, 1'b0);
    chk16("rst_addr", imem_addr, 16'h0000);
    chk1("rst_valid", instr_valid, 1'b0);
    chk16("rst_instr", instr, 16'h0000);
    chk16("rst_ipc", instr_pc, 16'h0000);
    chk1("rst_halted", halted, 1'b0);
    rst_n = 1'b1;

    // zero-wait memory, PC 0..3
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].st, tbl[i].fl);
      sample();
      chk1("tbl_pc_hlt", pc_hlt, tbl[i].e_hlt);
      chk1("tbl_req", imem_req, tbl[i].e_req);
      chk1("tbl_valid", instr_valid, tbl[i].e_val);
      chk16("tbl_ipc", instr_pc, tbl[i].e_pc);
      chk16("tbl_instr", instr, tbl[i].e_ins);
      advance();
    end

    // decode back-pressure fills the queue
    repeat (8) cyc(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    sample();
    chk1("full_pc_hlt", pc_hlt, 1'b1);
    chk1("full_req", imem_req, 1'b0);
    chk16("full_ipc", instr_pc, 16'h0004);
    chk16("full_instr", instr, 16'h1004);
    advance();
    drive(1'b0, 1'b0);
    sample();
    chk16("drain0_ipc", instr_pc, 16'h0004);
    chk1("drain0_pc_hlt", pc_hlt, 1'b1);
    advance();
    drive(1'b0, 1'b0);
    sample();
    chk16("drain1_ipc", instr_pc, 16'h0005);
    chk1("resume_pc_hlt", pc_hlt, 1'b0);
    lat = 3;
    advance();

    // 3-cycle memory latency on pc 6
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b0);
      sample();
      chk1("lat_req", imem_req, 1'b1);
      chk16("lat_addr", imem_addr, 16'h0006);
      chk1("lat_pc_hlt", pc_hlt, 1'b1);
      advance();
    end
    drive(1'b0, 1'b0);
    sample();
    chk1("lat_valid", instr_valid, 1'b1);
    chk16("lat_ipc", instr_pc, 16'h0006);
    chk16("lat_instr", instr, 16'h1006);
    chk1("lat_next_issue", pc_hlt, 1'b0);
    lat = 2;
    advance();

    // flush while waiting, ack lands two cycles later
    drive(1'b0, 1'b1);
    sample();
    chk1("fl_req", imem_req, 1'b1);
    chk16("fl_addr", imem_addr, 16'h0007);
    chk1("fl_valid", instr_valid, 1'b0);
    advance();
    pc_in = 16'h0123;
    drive(1'b0, 1'b0);
    sample();
    chk1("drop_req", imem_req, 1'b1);
    chk1("drop_pc_hlt", pc_hlt, 1'b1);
    chk1("drop_valid", instr_valid, 1'b0);
    advance();
    drive(1'b0, 1'b0);
    sample();
    chk1("drop_ack_valid", instr_valid, 1'b0);
    chk1("drop_ack_req", imem_req, 1'b1);
    advance();
    drive(1'b0, 1'b0);
    sample();
    chk1("post_drop_valid", instr_valid, 1'b0);
    chk1("post_drop_pc_hlt", pc_hlt, 1'b0);
    lat = 0;
    advance();
    drive(1'b0, 1'b0);
    sample();
    chk16("new_pc_addr", imem_addr, 16'h0123);
    chk1("new_pc_req", imem_req, 1'b1);
    advance();

    // HLT word at pc 5
    hlt_en   = 1'b1;
    hlt_addr = 16'h0005;
    pc_in    = 16'h0005;
    for (int n = 0; n < 20 && !halted; n++) cyc(1'b0, 1'b0);
    chk1("halt_seen", halted, 1'b1);
    drive(1'b0, 1'b0);
    sample();
    chk16("halt_ipc", instr_pc, 16'h0005);
    chk16("halt_instr", instr, 16'hF000);
    advance();
    for (int n = 0; n < 10; n++) begin
      drive(1'b0, 1'b0);
      sample();
      chk1("halt_pc_hlt", pc_hlt, 1'b1);
      chk1("halt_hold", halted, 1'b1);
      advance();
    end
    cyc(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    sample();
    chk1("unhalt", halted, 1'b0);
    chk1("unhalt_pc_hlt", pc_hlt, 1'b0);
    advance();
    hlt_en = 1'b0;

    // reset mid-fetch with a non-empty queue
    lat = 3;
    found = 1'b0;
    for (int n = 0; n < 30; n++) begin
      drive(1'b1, 1'b0);
      sample();
      if (m_out && mq.size() != 0) begin
        found = 1'b1;
        break;
      end
      advance();
    end
    chk1("rst_setup", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_req", imem_req, 1'b0);
    chk16("arst_addr", imem_addr, 16'h0000);
    chk1("arst_valid", instr_valid, 1'b0);
    chk16("arst_instr", instr, 16'h0000);
    chk16("arst_ipc", instr_pc, 16'h0000);
    chk1("arst_halted", halted, 1'b0);
    chk1("arst_pc_hlt", pc_hlt, 1'b1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    lat   = 0;
    pc_in = 16'h0040;
    drive(1'b0, 1'b0);
    sample();
    chk1("rel_pc_hlt", pc_hlt, 1'b0);
    advance();
    drive(1'b0, 1'b0);
    sample();
    chk16("rel_addr", imem_addr, 16'h0040);
    chk1("rel_req", imem_req, 1'b1);
    advance();

    // random traffic against the model
    rand_mode = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic st;
      logic fl;
      st = $urandom_range(0, 9) < 3;
      fl = $urandom_range(0, 29) == 0;
      if (fl && $urandom_range(0, 1) == 1) pc_in = 16'($urandom);
      cyc(st, fl);
    end
    rand_mode = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
